// File: rtl/sdram_arbit.sv
// sdram_arbit: fixed-priority arbiter sharing one SDRAM command bus between init, refresh, write and read engines.
// Ports:
//   clk, rst_n                   clock; asynchronous active-low reset
//   init_end_i, init_*_i         init engine done flag and its command bus
//   ar_req_i/ar_end_i, ar_*_i    refresh request, done pulse and command bus
//   wr_req_i/wr_end_i, wr_*_i    write request, done pulse, command bus and data
//   rd_req_i/rd_end_i, rd_*_i    read request, done pulse and command bus
//   ar_en_o/wr_en_o/rd_en_o      registered grants, one-hot or all low
//   sdram_*_o                    muxed SDRAM command/address/data bus
//   timeout_err_o                one-cycle pulse when the watchdog forces a return
module sdram_arbit #(
  parameter int TIMEOUT = 1023,
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_end_i,
  input  logic [3:0]  init_cmd_i,
  input  logic [1:0]  init_bank_i,
  input  logic [12:0] init_addr_i,
  input  logic        ar_req_i,
  input  logic        ar_end_i,
  input  logic [3:0]  ar_cmd_i,
  input  logic [1:0]  ar_bank_i,
  input  logic [12:0] ar_addr_i,
  input  logic        wr_req_i,
  input  logic        wr_end_i,
  input  logic [3:0]  wr_cmd_i,
  input  logic [1:0]  wr_bank_i,
  input  logic [12:0] wr_addr_i,
  input  logic        wr_dq_oe_i,
  input  logic [15:0] wr_dq_i,
  input  logic        rd_req_i,
  input  logic        rd_end_i,
  input  logic [3:0]  rd_cmd_i,
  input  logic [1:0]  rd_bank_i,
  input  logic [12:0] rd_addr_i,
  output logic        ar_en_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic [3:0]  sdram_cmd_o,
  output logic [1:0]  sdram_bank_o,
  output logic [12:0] sdram_addr_o,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe_o,
  output logic        timeout_err_o
);
  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;
  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        busy, end_flag, wd_hit;
  assign busy     = state_q inside {AREF, WRITE, READ};
  assign end_flag = state_q == AREF ? ar_end_i : state_q == WRITE ? wr_end_i : state_q == READ ? rd_end_i : 1'b0;
  // counter holds the number of completed cycles in the state, so the
  // last permitted cycle is the one where it reads TIMEOUT-1
  assign wd_hit   = busy && cnt_q == 10'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    to_d    = 1'b0;
    case (state_q)
      INIT:  state_d = init_end_i ? ARBIT : INIT;
      ARBIT: state_d = ar_req_i ? AREF : wr_req_i ? WRITE : rd_req_i ? READ : ARBIT;
      AREF, WRITE, READ: begin
        // end flag takes precedence over a coincident watchdog expiry
        if (end_flag || wd_hit) state_d = ARBIT;
        to_d = wd_hit && !end_flag;
      end
      default: state_d = INIT;
    endcase
    cnt_d = busy && state_d == state_q ? cnt_q + 10'd1 : 10'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= 10'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  assign ar_en_o       = state_q == AREF;
  assign wr_en_o       = state_q == WRITE;
  assign rd_en_o       = state_q == READ;
  assign timeout_err_o = to_q;
  always_comb begin
    sdram_cmd_o  = NOP_CMD;
    sdram_bank_o = 2'b11;
    sdram_addr_o = 13'h1FFF;
    case (state_q)
      INIT:  {sdram_cmd_o, sdram_bank_o, sdram_addr_o} = {init_cmd_i, init_bank_i, init_addr_i};
      AREF:  {sdram_cmd_o, sdram_bank_o, sdram_addr_o} = {ar_cmd_i, ar_bank_i, ar_addr_i};
      WRITE: {sdram_cmd_o, sdram_bank_o, sdram_addr_o} = {wr_cmd_i, wr_bank_i, wr_addr_i};
      READ:  {sdram_cmd_o, sdram_bank_o, sdram_addr_o} = {rd_cmd_i, rd_bank_i, rd_addr_i};
      default: ;
    endcase
  end
  assign sdram_dq_oe_o = wr_en_o ? wr_dq_oe_i : 1'b0;
  assign sdram_dq_o    = wr_en_o ? wr_dq_i : 16'h0;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed self-checking bench for sdram_arbit with TIMEOUT=8.
module tb_sdram_arbit;
  logic clk = 0, rst_n = 0;
  logic init_end = 0, ar_req = 0, ar_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
  logic wr_dq_oe = 0;
  logic [15:0] wr_dq = 16'h0;
  logic ar_en, wr_en, rd_en, sdram_dq_oe, timeout_err;
  logic [3:0] sdram_cmd;
  logic [1:0] sdram_bank;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sdram_arbit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_end_i(init_end), .init_cmd_i(4'h1), .init_bank_i(2'd0), .init_addr_i(13'h0011),
    .ar_req_i(ar_req), .ar_end_i(ar_end), .ar_cmd_i(4'h2), .ar_bank_i(2'd1), .ar_addr_i(13'h0022),
    .wr_req_i(wr_req), .wr_end_i(wr_end), .wr_cmd_i(4'h3), .wr_bank_i(2'd2), .wr_addr_i(13'h0033),
    .wr_dq_oe_i(wr_dq_oe), .wr_dq_i(wr_dq),
    .rd_req_i(rd_req), .rd_end_i(rd_end), .rd_cmd_i(4'h4), .rd_bank_i(2'd0), .rd_addr_i(13'h0044),
    .ar_en_o(ar_en), .wr_en_o(wr_en), .rd_en_o(rd_en),
    .sdram_cmd_o(sdram_cmd), .sdram_bank_o(sdram_bank), .sdram_addr_o(sdram_addr),
    .sdram_dq_o(sdram_dq), .sdram_dq_oe_o(sdram_dq_oe), .timeout_err_o(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_grants", {ar_en, wr_en, rd_en}, 3'b000);
    chk("rst_to", timeout_err, 0);
    chk("rst_bus", {sdram_cmd, sdram_bank, sdram_addr}, {4'h1, 2'd0, 13'h0011});
    #3 rst_n = 1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (sdram_cmd !== 4'h1) chk("init_cmd", sdram_cmd, 4'h1);
    end
    chk("init_cmd_c19", sdram_cmd, 4'h1);
    init_end = 1;
    tick();
    chk("arbit_bus", {sdram_cmd, sdram_bank, sdram_addr}, {4'h7, 2'b11, 13'h1FFF});
    init_end = 0;
    tick();
    chk("init_end_fall", sdram_cmd, 4'h7);
    {ar_req, wr_req, rd_req} = 3'b111;
    tick();
    chk("pri_ar", {ar_en, wr_en, rd_en}, 3'b100);
    chk("ar_bus", {sdram_cmd, sdram_bank, sdram_addr}, {4'h2, 2'd1, 13'h0022});
    ar_req = 0;
    wr_end = 1;
    tick();
    chk("foreign_end", {ar_en, wr_en, rd_en}, 3'b100);
    wr_end = 0;
    ar_end = 1;
    tick();
    ar_end = 0;
    chk("ar_done_nop", {ar_en, wr_en, rd_en, sdram_cmd}, {3'b000, 4'h7});
    tick();
    chk("pri_wr", {ar_en, wr_en, rd_en}, 3'b010);
    wr_req = 0;
    wr_dq_oe = 1;
    wr_dq = 16'hA5A5;
    #1;
    chk("wr_dq", {sdram_dq_oe, sdram_dq}, {1'b1, 16'hA5A5});
    chk("wr_bus", {sdram_cmd, sdram_bank, sdram_addr}, {4'h3, 2'd2, 13'h0033});
    wr_end = 1;
    tick();
    wr_end = 0;
    chk("wr_done_nop", {ar_en, wr_en, rd_en, sdram_cmd, sdram_dq_oe}, {3'b000, 4'h7, 1'b0});
    tick();
    chk("pri_rd", {ar_en, wr_en, rd_en}, 3'b001);
    chk("rd_dq", {sdram_dq_oe, sdram_dq}, {1'b0, 16'h0});
    chk("rd_bus", {sdram_cmd, sdram_bank, sdram_addr}, {4'h4, 2'd0, 13'h0044});
    rd_req = 0;
    ar_req = 1;
    tick();
    chk("rd_hold", {ar_en, wr_en, rd_en}, 3'b001);
    rd_end = 1;
    tick();
    rd_end = 0;
    chk("rd_done", {ar_en, wr_en, rd_en}, 3'b000);
    tick();
    chk("ar_after_rd", {ar_en, wr_en, rd_en}, 3'b100);
    ar_req = 0;
    ar_end = 1;
    tick();
    ar_end = 0;
    wr_req = 1;
    tick();
    wr_req = 0;
    chk("wd_wr_c1", wr_en, 1);
    for (int i = 2; i <= 8; i++) tick();
    chk("wd_wr_c8", {wr_en, timeout_err}, 2'b10);
    tick();
    chk("wd_expire", {wr_en, timeout_err, sdram_cmd}, {2'b01, 4'h7});
    tick();
    chk("wd_pulse_end", timeout_err, 0);
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int i = 2; i <= 8; i++) tick();
    chk("co_c8", wr_en, 1);
    wr_end = 1;
    tick();
    wr_end = 0;
    chk("co_end_wins", {wr_en, timeout_err}, 2'b00);
    tick();
    chk("co_no_pulse", timeout_err, 0);
    ar_req = 1;
    tick();
    ar_req = 0;
    chk("ar_pre_rst", ar_en, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst", {ar_en, sdram_cmd}, {1'b0, 4'h1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter TIMEOUT, default 1023, maximum cycles any of AREF/WRITE/READ may run without its end flag.
REQ-002 Parameter NOP_CMD, default 4'b0111, idle command driven as {cs_n,ras_n,cas_n,we_n}.
REQ-003 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init_end  in  1  initialization complete, stays high once set; init_cmd/init_bank/init_addr  in  4/2/13  init module bus.
REQ-005 ar_req  in  1  refresh request; ar_end  in  1  refresh done pulse; ar_cmd/ar_bank/ar_addr  in  4/2/13.
REQ-006 wr_req  in  1  write request; wr_end  in  1  write done pulse; wr_cmd/wr_bank/wr_addr  in  4/2/13; wr_dq_oe  in  1; wr_dq  in  16.
REQ-007 rd_req  in  1  read request; rd_end  in  1  read done pulse; rd_cmd/rd_bank/rd_addr  in  4/2/13.
REQ-008 ar_en/wr_en/rd_en  out  1  grant to the owning requester.
REQ-009 sdram_cmd/sdram_bank/sdram_addr  out  4/2/13  muxed SDRAM command bus; sdram_dq  out  16; sdram_dq_oe  out  1.
REQ-010 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-011 FSM states SHALL be INIT, ARBIT, AREF, WRITE, READ; all transitions on posedge clk.
REQ-012 INIT -> ARBIT on the first cycle init_end is sampled high.
REQ-013 ARBIT SHALL use fixed priority ar_req > wr_req > rd_req: ARBIT -> AREF, WRITE or READ, whichever is highest and asserted; otherwise stays in ARBIT.
REQ-014 Grant SHALL be registered: ar_en/wr_en/rd_en rise on the same edge that enters AREF/WRITE/READ and are high exactly while in that state; at most one is high at any time.
REQ-015 AREF/WRITE/READ -> ARBIT on the edge where the matching ar_end/wr_end/rd_end is sampled high; the grant drops on that edge.
REQ-016 Every return passes through ARBIT for at least one cycle; back-to-back grants are separated by at least one NOP cycle.
REQ-017 Requests arriving while another owner holds the bus SHALL be ignored until ARBIT; requesters hold req high until granted.
REQ-018 End flags not belonging to the current state SHALL be ignored.
REQ-019 Bus mux (combinational from state): INIT -> init_*; AREF -> ar_*; WRITE -> wr_*; READ -> rd_*; ARBIT -> NOP_CMD, bank 2'b11, addr 13'h1FFF.
REQ-020 sdram_dq_oe = wr_dq_oe only in WRITE, else 0; sdram_dq = wr_dq in WRITE, else 16'h0.
REQ-021 Watchdog: a 10-bit counter clears on entry to AREF/WRITE/READ and increments each cycle in that state.
REQ-022 On reaching TIMEOUT without the end flag: force ARBIT, drop the grant, and pulse timeout_err for 1 cycle; the counter holds 0 in ARBIT and INIT.
REQ-023 If the end flag and timeout coincide, the end flag wins and no timeout_err is raised.
REQ-024 init_end falling after INIT SHALL be ignored; only reset returns to INIT.

Reset
REQ-025 While rst_n is low: state INIT, all grants 0, timeout_err 0, watchdog counter 0.
REQ-026 Bus SHALL follow init_* immediately after reset.
REQ-027 Reset asserted mid-operation SHALL abort asynchronously to INIT with grants dropped, with no end flag needed.

Verification
REQ-028 Reset released, init_end rises at cycle 20 -> sdram_cmd mirrors init_cmd until cycle 20, then 4'b0111 in ARBIT.
REQ-029 ar_req, wr_req and rd_req high together in ARBIT -> ar_en=1 next edge; after ar_end, 1 NOP cycle, then wr_en=1; after wr_end, 1 NOP cycle, then rd_en=1.
REQ-030 During READ, ar_req rises -> rd_en stays 1 until rd_end; ar_en rises 2 cycles after rd_end.
REQ-031 With TIMEOUT=8, grant WRITE and never assert wr_end -> wr_en falls after 8 cycles in WRITE, timeout_err pulses once, bus returns to NOP.
REQ-032 In WRITE with wr_dq_oe=1 and wr_dq=16'hA5A5 -> sdram_dq=16'hA5A5, sdram_dq_oe=1; in READ -> sdram_dq_oe=0.
REQ-033 rst_n asserted while in AREF -> ar_en=0 and state INIT without waiting for a clock edge.
